// File: rtl/setting_sweep_ctrl_pkg.sv
// Shared types and default widths for the tx/rx setting sweep sequencer.
// The setting-width defaults track the emulator's tx and filter packages.
package sweep_package;

  localparam int TX_SETTING_WIDTH_DEF = 4;
  localparam int RX_SETTING_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF        = 32;
  localparam int CYC_WIDTH            = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_REPORT  = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } sweep_state_e;

  // One result record at the default widths.
  typedef struct packed {
    logic [TX_SETTING_WIDTH_DEF-1:0] tx;
    logic [RX_SETTING_WIDTH_DEF-1:0] rx;
    logic [CNT_WIDTH_DEF-1:0]        bits;
    logic [CNT_WIDTH_DEF-1:0]        errs;
  } sweep_rec_t;

endpackage

// File: rtl/setting_sweep_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/setting_sweep_ctrl.sv
// Drives the emulator through every (tx, rx) setting pair, rx inner and tx outer.
// Each point: reset pulse, settle window, bit/error count, one handshaked result record.
module setting_sweep_ctrl
  import sweep_package::*;
#(
  parameter int TX_SETTING_WIDTH = TX_SETTING_WIDTH_DEF,
  parameter int RX_SETTING_WIDTH = RX_SETTING_WIDTH_DEF,
  parameter int TX_MAX           = 15,
  parameter int RX_MAX           = 15,
  parameter int RST_CYCLES       = 16,
  parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 settle_cycles,
  input  logic [CNT_WIDTH-1:0]        meas_bits,
  input  logic                        bit_valid,
  input  logic                        bit_err,
  output logic [TX_SETTING_WIDTH-1:0] tx_setting,
  output logic [RX_SETTING_WIDTH-1:0] rx_setting,
  output logic                        emu_rst,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [TX_SETTING_WIDTH-1:0] res_tx,
  output logic [RX_SETTING_WIDTH-1:0] res_rx,
  output logic [CNT_WIDTH-1:0]        res_bits,
  output logic [CNT_WIDTH-1:0]        res_errs,
  output logic                        busy,
  output logic                        sim_done
);

  localparam logic [TX_SETTING_WIDTH-1:0] TX_LAST    = TX_SETTING_WIDTH'(TX_MAX);
  localparam logic [RX_SETTING_WIDTH-1:0] RX_LAST    = RX_SETTING_WIDTH'(RX_MAX);
  localparam logic [CYC_WIDTH-1:0]        APPLY_LAST = CYC_WIDTH'(RST_CYCLES - 1);

  sweep_state_e                state_q, state_d;
  logic [CYC_WIDTH-1:0]        cyc_q, cyc_d;
  logic [15:0]                 settle_q, settle_d;
  logic [CNT_WIDTH-1:0]        target_q, target_d;
  logic [TX_SETTING_WIDTH-1:0] tx_q, tx_d;
  logic [RX_SETTING_WIDTH-1:0] rx_q, rx_d;

  logic [CNT_WIDTH-1:0] bits_cnt, errs_cnt;
  logic start_ok, last_point, cnt_clr, bit_inc, err_inc, meas_done;

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_point = (tx_q == TX_LAST) && (rx_q == RX_LAST);
  assign bit_inc    = (state_q == ST_MEASURE) && bit_valid;
  assign err_inc    = bit_inc && bit_err;
  assign cnt_clr    = start_ok || (state_q == ST_NEXT);
  // The completing bit is the one that lifts the count from target-1 to target.
  assign meas_done  = bit_inc && (bits_cnt == target_q - 1'b1);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (bit_inc),
    .count (bits_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (err_inc),
    .count (errs_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      settle_q <= '0;
      target_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      settle_q <= settle_d;
      target_q <= target_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
      // A zero settle window skips SETTLE entirely.
      ST_APPLY:   if (cyc_q == APPLY_LAST) state_d = (settle_cycles == '0) ? ST_MEASURE : ST_SETTLE;
      ST_SETTLE:  if (cyc_q == settle_q - 1'b1) state_d = ST_MEASURE;
      ST_MEASURE: if (meas_done) state_d = ST_REPORT;
      ST_REPORT:  if (res_ready) state_d = ST_NEXT;
      ST_NEXT:    state_d = last_point ? ST_DONE : ST_APPLY;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d    = '0;
    settle_d = settle_q;
    target_d = target_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if ((state_d == state_q) && ((state_q == ST_APPLY) || (state_q == ST_SETTLE))) begin
      cyc_d = cyc_q + 1'b1;
    end
    if ((state_q == ST_APPLY) && (state_d == ST_SETTLE)) begin
      settle_d = settle_cycles;
    end
    if ((state_d == ST_MEASURE) && (state_q != ST_MEASURE)) begin
      target_d = (meas_bits == '0) ? CNT_WIDTH'(1) : meas_bits;
    end
    if (start_ok) begin
      tx_d = '0;
      rx_d = '0;
    end else if ((state_q == ST_NEXT) && !last_point) begin
      if (rx_q == RX_LAST) begin
        rx_d = '0;
        tx_d = tx_q + 1'b1;
      end else begin
        rx_d = rx_q + 1'b1;
      end
    end
  end

  // Counters and settings are frozen outside MEASURE/NEXT, so they form the record directly.
  always_comb begin
    emu_rst    = (state_q == ST_IDLE) || (state_q == ST_APPLY) || (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    sim_done   = (state_q == ST_DONE);
    res_valid  = (state_q == ST_REPORT);
    tx_setting = tx_q;
    rx_setting = rx_q;
    res_tx     = tx_q;
    res_rx     = rx_q;
    res_bits   = bits_cnt;
    res_errs   = errs_cnt;
  end

endmodule

// File: tb/tb_setting_sweep_ctrl.sv
// Directed bench for setting_sweep_ctrl on a small 2x3 sweep with 4-bit counters,
// checked every cycle against a procedural model of the sweep plus literal record checks.
module tb_setting_sweep_ctrl;

  localparam int TXW = 4;
  localparam int RXW = 4;
  localparam int TX_MAX = 1;
  localparam int RX_MAX = 2;
  localparam int RST_CYCLES = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk, rst_n, start, bit_valid, bit_err, res_ready;
  logic [15:0] settle_cycles;
  logic [CW-1:0] meas_bits;
  logic [TXW-1:0] tx_setting, res_tx;
  logic [RXW-1:0] rx_setting, res_rx;
  logic emu_rst, res_valid, busy, sim_done;
  logic [CW-1:0] res_bits, res_errs;

  setting_sweep_ctrl #(
    .TX_SETTING_WIDTH(TXW), .RX_SETTING_WIDTH(RXW), .TX_MAX(TX_MAX), .RX_MAX(RX_MAX),
    .RST_CYCLES(RST_CYCLES), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .settle_cycles(settle_cycles),
    .meas_bits(meas_bits), .bit_valid(bit_valid), .bit_err(bit_err),
    .tx_setting(tx_setting), .rx_setting(rx_setting), .emu_rst(emu_rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_tx(res_tx), .res_rx(res_rx),
    .res_bits(res_bits), .res_errs(res_errs), .busy(busy), .sim_done(sim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit exp_emu_rst, exp_busy, exp_done, exp_valid, exp_rst_state, abort;
  int exp_tx, exp_rx, exp_rtx, exp_rrx, exp_bits, exp_errs;

  task automatic set_reset_exp();
    exp_emu_rst = 1; exp_busy = 0; exp_done = 0; exp_valid = 0; exp_rst_state = 1;
    exp_tx = 0; exp_rx = 0; exp_rtx = 0; exp_rrx = 0; exp_bits = 0; exp_errs = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) abort = 1;
  endtask

  // Walks one full sweep; returns early if reset is seen at any edge.
  task automatic run_sweep();
    int s, tgt, nb, ne;
    abort = 0; exp_rst_state = 0; exp_busy = 1; exp_done = 0;
    for (int t = 0; t <= TX_MAX; t++) begin
      for (int r = 0; r <= RX_MAX; r++) begin
        exp_tx = t; exp_rx = r; exp_emu_rst = 1;
        repeat (RST_CYCLES) begin step(); if (abort) return; end
        exp_emu_rst = 0;
        s = int'(settle_cycles);
        repeat (s) begin step(); if (abort) return; end
        tgt = (meas_bits == 0) ? 1 : int'(meas_bits);
        nb = 0; ne = 0;
        while (nb < tgt) begin
          step(); if (abort) return;
          if (bit_valid) begin
            nb++;
            if (bit_err && ne < CMAX) ne++;
          end
        end
        exp_valid = 1; exp_rtx = t; exp_rrx = r; exp_bits = nb; exp_errs = ne;
        do begin step(); if (abort) return; end while (!res_ready);
        exp_valid = 0;
        step(); if (abort) return;
      end
    end
    exp_emu_rst = 1; exp_busy = 0; exp_done = 1;
  endtask

  initial begin : model
    set_reset_exp();
    abort = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) set_reset_exp();
      else if (start) begin
        run_sweep();
        if (abort) set_reset_exp();
      end
    end
  end

  // ---------------- compare + monitors ----------------
  typedef struct { int tx; int rx; int bits; int errs; } rec_t;
  rec_t seen[$];
  int rst_run = 0;
  int last_rst_run = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("emu_rst", emu_rst, exp_emu_rst);
      chk("busy", busy, exp_busy);
      chk("sim_done", sim_done, exp_done);
      chk("res_valid", res_valid, exp_valid);
      chk("tx_setting", tx_setting, exp_tx);
      chk("rx_setting", rx_setting, exp_rx);
      if (exp_valid || exp_rst_state) begin
        chk("res_tx", res_tx, exp_rtx);
        chk("res_rx", res_rx, exp_rrx);
        chk("res_bits", res_bits, exp_bits);
        chk("res_errs", res_errs, exp_errs);
      end
      if (res_valid && res_ready) begin
        seen.push_back('{int'(res_tx), int'(res_rx), int'(res_bits), int'(res_errs)});
        $display("record tx=%0d rx=%0d bits=%0d errs=%0d", res_tx, res_rx, res_bits, res_errs);
      end
      if (emu_rst) rst_run++;
      else begin
        if (rst_run > 0) last_rst_run = rst_run;
        rst_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int ex_tx [6] = '{0, 0, 0, 1, 1, 1};
  int ex_rx [6] = '{0, 1, 2, 0, 1, 2};
  bit pat_v [16] = '{0,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1};
  bit pat_e [16] = '{0,0,0,1,1,0,0,0,0,1,1,0,0,1,0,0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!sim_done && n < budget) begin tick(); n++; end
    chk("sweep_done_in_time", sim_done, 1);
  endtask

  task automatic check_sweep(input string tag, input int bits, input int errs);
    chk({tag, "_count"}, seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      chk({tag, "_tx"}, seen[i].tx, ex_tx[i]);
      chk({tag, "_rx"}, seen[i].rx, ex_rx[i]);
      chk({tag, "_bits"}, seen[i].bits, bits);
      chk({tag, "_errs"}, seen[i].errs, errs);
    end
  endtask

  initial begin : stim
    int n;
    rst_n = 0; start = 0; settle_cycles = 16'd3; meas_bits = 4'd10;
    bit_valid = 0; bit_err = 0; res_ready = 1;
    tick(); tick();
    chk_en = 1;
    rst_n = 1;
    chk("reset_emu_rst", emu_rst, 1);
    chk("reset_res_valid", res_valid, 0);

    // Full sweep, continuous valid bits, no errors.
    bit_valid = 1;
    pulse_start();
    wait_done(400);
    check_sweep("sweep1", 10, 0);
    chk("apply_rst_len", last_rst_run, RST_CYCLES);
    chk("done_busy", busy, 0);

    // Restart from DONE: alternating valid bits with a fixed error pattern on point (0,0).
    seen.delete();
    settle_cycles = 16'd0; meas_bits = 4'd8; bit_valid = 0; bit_err = 0;
    pulse_start();
    chk("restart_clears_done", sim_done, 0);
    n = 0;
    while (emu_rst && n < 50) begin tick(); n++; end
    chk("measure_reached", emu_rst, 0);
    for (int k = 0; k < 16; k++) begin
      bit_valid = pat_v[k]; bit_err = pat_e[k];
      tick();
    end
    bit_valid = 1; bit_err = 0;
    pulse_start();
    chk("start_ignored_busy", busy, 1);
    wait_done(400);
    chk("pattern_count", seen.size(), 6);
    if (seen.size() == 6) begin
      chk("pattern_bits", seen[0].bits, 8);
      chk("pattern_errs", seen[0].errs, 3);
      chk("pattern_last_rx", seen[5].rx, 2);
      chk("pattern_last_errs", seen[5].errs, 0);
    end

    // Every bit in error at full counter range, with back-pressure on the first record.
    seen.delete();
    settle_cycles = 16'd3; meas_bits = 4'd15; bit_valid = 1; bit_err = 1; res_ready = 0;
    pulse_start();
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("report_reached", res_valid, 1);
    repeat (19) tick();
    chk("held_valid", res_valid, 1);
    chk("held_bits", res_bits, 15);
    chk("held_errs", res_errs, 15);
    chk("held_rx_setting", rx_setting, 0);
    res_ready = 1;
    tick();
    chk("next_rx_setting", rx_setting, 0);
    tick();
    chk("advanced_rx_setting", rx_setting, 1);
    wait_done(400);
    check_sweep("sat", 15, 15);

    // Reset in the middle of measuring point (1,0).
    seen.delete();
    settle_cycles = 16'd3; meas_bits = 4'd10; bit_err = 0;
    pulse_start();
    n = 0;
    while (!(tx_setting == 1 && !emu_rst) && n < 400) begin tick(); n++; end
    chk("point_1_0_reached", tx_setting, 1);
    repeat (5) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_emu_rst", emu_rst, 1);
    chk("midrst_tx", tx_setting, 0);
    repeat (5) tick();
    chk("midrst_records", seen.size(), 3);

    // Zero settle window and zero bit target: one bit per point.
    seen.delete();
    settle_cycles = 16'd0; meas_bits = 4'd0;
    pulse_start();
    wait_done(300);
    check_sweep("zero", 1, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/setting_sweep_ctrl.md
Name: setting_sweep_ctrl

Overview:
Sequencer that drives the link emulator's tx_setting/rx_setting through a full 2-D sweep for an unattended run. Per point: pulse the emulator reset, wait a settle window, count received bits and bit errors, then report one result record over a valid/ready handshake. Asserts sim_done when the sweep completes. Sits between the top-level config path (VIO or bench) and the dut emulator core, replacing static tx_setting_ext/rx_setting_ext/rst_ext drive.

Parameters:
TX_SETTING_WIDTH, 4, width of tx_setting (matches tx_package).
RX_SETTING_WIDTH, 4, width of rx_setting (matches filter_package).
TX_MAX, 15, last tx_setting value swept (inclusive).
RX_MAX, 15, last rx_setting value swept (inclusive).
RST_CYCLES, 16, emulator reset pulse length in clk cycles.
CNT_WIDTH, 32, width of bit and error counters.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins sweep from (tx=0, rx=0)
settle_cycles  in  16  cycles waited after emulator reset release
meas_bits  in  CNT_WIDTH  received bits counted per point
bit_valid  in  1  emulator produced a received bit this cycle
bit_err  in  1  that bit mismatched reference (qualified by bit_valid)
tx_setting  out  TX_SETTING_WIDTH  setting to emulator TX
rx_setting  out  RX_SETTING_WIDTH  setting to emulator RX
emu_rst  out  1  active-high reset to emulator core
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts record
res_tx  out  TX_SETTING_WIDTH  tx_setting of record
res_rx  out  RX_SETTING_WIDTH  rx_setting of record
res_bits  out  CNT_WIDTH  bits counted
res_errs  out  CNT_WIDTH  errors counted (saturating)
busy  out  1  sweep in progress
sim_done  out  1  sweep complete, sticky

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; tx_setting=0, rx_setting=0, emu_rst=1, res_valid=0, res_*=0, busy=0, sim_done=0, counters 0.
- States: IDLE, APPLY, SETTLE, MEASURE, REPORT, NEXT, DONE.
- IDLE: emu_rst=1. start -> APPLY, settings 0/0, busy=1, sim_done=0.
- APPLY: emu_rst=1 for exactly RST_CYCLES cycles, then -> SETTLE with emu_rst=0 on the first SETTLE cycle.
- SETTLE: count settle_cycles cycles (value sampled on entry); 0 means zero-length, go straight to MEASURE next cycle. bit_valid ignored.
- MEASURE: each bit_valid=1 cycle increments bit count; bit_valid&bit_err increments err count, saturating at all-ones. bit_err without bit_valid ignored. When bit count reaches meas_bits (sampled on entry; 0 treated as 1) -> REPORT; the completing bit is included.
- REPORT: res_valid=1, res_* stable until res_valid&res_ready cycle; then -> NEXT. res_valid never drops without handshake. Emulator keeps running; bits ignored.
- NEXT (one cycle): if rx==RX_MAX and tx==TX_MAX -> DONE; else if rx==RX_MAX: rx=0, tx+=1; else rx+=1. -> APPLY. Counters cleared. Settings change only in NEXT (and on start).
- DONE: sim_done=1, busy=0, emu_rst=1, settings hold last point. start -> restart sweep as from IDLE (sim_done cleared same edge).
- start while busy: ignored.
- Total records = (TX_MAX+1)*(RX_MAX+1), order rx-inner, tx-outer.
- Reset mid-sweep: immediate return to reset values; no partial record emitted.
- Latency start -> first MEASURE cycle = 1 + RST_CYCLES + settle_cycles cycles.

Decomposition:
- Shared package sweep_package: state enum typedef, result record struct (tx, rx, bits, errs), CNT_WIDTH default. TX/RX setting widths come from tx_package/filter_package.
- One sub-module: sat_counter (parameterized width, clear, inc, saturates at max), instantiated for bit and error counts; plain cycle counter for APPLY/SETTLE inline.

Test Plan:
- TX_MAX=1, RX_MAX=2, RST_CYCLES=4, settle=3, meas_bits=10, bit_valid=1 always, no errors -> 6 records in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), each bits=10 errs=0; then sim_done=1, busy=0.
- Single point, bit_valid every other cycle, bit_err on 3 valid bits and 2 invalid cycles, meas_bits=8 -> record bits=8 errs=3; emu_rst high exactly 4 cycles before settle.
- CNT_WIDTH=4, bit_err=1 on every valid bit, meas_bits=15 -> errs=15 saturated, bits=15, no wrap.
- res_ready held low 20 cycles in REPORT -> res_valid and res_* stable for 20 cycles; settings unchanged until one cycle after handshake.
- Assert rst_n=0 mid-MEASURE on point (1,0) -> next edge all outputs at reset values, no res_valid; later start restarts at (0,0).
- start pulsed while busy -> ignored; start in DONE -> sim_done falls, sweep reruns; settle_cycles=0 and meas_bits=0 -> one bit counted per point, no hang.
